// File: rtl/matrix_feeder.sv
`default_nettype none
// ============================================================================
// Module   : matrix_feeder
// Purpose  : Loads A and B operands (row-major) over a valid/ready stream,
//            then drives a systolic array's edges with diagonal skew.
// Revision : 1.0 - initial release
// ============================================================================
module matrix_feeder #(
    parameter int N            = 3,
    parameter int W            = 8,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_data,
    output logic           acc_clr,
    output logic           feed_valid,
    output logic [N*W-1:0] a_out,
    output logic [N*W-1:0] b_out,
    output logic           done
);

    localparam int c_NN   = N * N;
    localparam int c_MAXC = (2 * c_NN > DRAIN_CYCLES) ? 2 * c_NN : DRAIN_CYCLES;
    localparam int c_CW   = $clog2(c_MAXC + 1);

    localparam logic [c_CW-1:0] c_LOAD_LAST  = c_CW'(2 * c_NN - 1);
    localparam logic [c_CW-1:0] c_FEED_LAST  = c_CW'(2 * N - 2);
    localparam logic [c_CW-1:0] c_DRAIN_LAST = c_CW'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_CLEAR = 3'd2;
    localparam logic [2:0] S_FEED  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]        r_state;
    logic [c_CW-1:0]   r_cnt;
    logic [c_NN*W-1:0] r_a;
    logic [c_NN*W-1:0] r_b;

    logic [c_CW-1:0]   w_t_next;
    logic [N*W-1:0]    w_a_next;
    logic [N*W-1:0]    w_b_next;

    // Lanes are registered, so they are computed for the beat that follows this edge.
    assign w_t_next = (r_state == S_FEED) ? r_cnt + 1'b1 : '0;

    always_comb begin
        w_a_next = '0;
        w_b_next = '0;
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < N; k++) begin
                if (int'(w_t_next) == i + k) begin
                    w_a_next[i*W +: W] = r_a[(i*N + k)*W +: W];
                    w_b_next[i*W +: W] = r_b[(k*N + i)*W +: W];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_a        <= '0;
            r_b        <= '0;
            in_ready   <= 1'b0;
            acc_clr    <= 1'b0;
            feed_valid <= 1'b0;
            a_out      <= '0;
            b_out      <= '0;
            done       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state  <= S_LOAD;
                        r_cnt    <= '0;
                        in_ready <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (in_valid && in_ready) begin
                        for (int k = 0; k < c_NN; k++) begin
                            if (int'(r_cnt) == k)        r_a[k*W +: W] <= in_data;
                            if (int'(r_cnt) == k + c_NN) r_b[k*W +: W] <= in_data;
                        end
                        if (r_cnt == c_LOAD_LAST) begin
                            r_state  <= S_CLEAR;
                            in_ready <= 1'b0;
                            acc_clr  <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_CLEAR: begin
                    r_state    <= S_FEED;
                    r_cnt      <= '0;
                    acc_clr    <= 1'b0;
                    feed_valid <= 1'b1;
                    a_out      <= w_a_next;
                    b_out      <= w_b_next;
                end
                S_FEED: begin
                    if (r_cnt == c_FEED_LAST) begin
                        r_cnt      <= '0;
                        feed_valid <= 1'b0;
                        a_out      <= '0;
                        b_out      <= '0;
                        if (DRAIN_CYCLES == 0) begin
                            r_state <= S_DONE;
                            done    <= 1'b1;
                        end else begin
                            r_state <= S_DRAIN;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        a_out <= w_a_next;
                        b_out <= w_b_next;
                    end
                end
                S_DRAIN: begin
                    if (r_cnt == c_DRAIN_LAST) begin
                        r_state <= S_DONE;
                        done    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    done    <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_matrix_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_matrix_feeder
// Purpose  : Self-checking bench for matrix_feeder against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_matrix_feeder;

    localparam int N  = 3;
    localparam int W  = 8;
    localparam int D  = 4;
    localparam int NN = N * N;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_data;
    logic           acc_clr;
    logic           feed_valid;
    logic [N*W-1:0] a_out;
    logic [N*W-1:0] b_out;
    logic           done;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] opA [N][N];
    logic [W-1:0] opB [N][N];

    // Observations of the most recent run
    logic [N*W-1:0] cap_a [$];
    logic [N*W-1:0] cap_b [$];
    int             cap_n [$];
    int n_clr, clr_cnt, n_done, done_cnt, last_acc_n, rdy_bad, lane_bad;

    matrix_feeder #(.N(N), .W(W), .DRAIN_CYCLES(D)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .acc_clr    (acc_clr),
        .feed_valid (feed_valid),
        .a_out      (a_out),
        .b_out      (b_out),
        .done       (done)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] elem(input int idx);
        if (idx < NN) return opA[idx / N][idx % N];
        return opB[(idx - NN) / N][(idx - NN) % N];
    endfunction

    function automatic logic [N*W-1:0] exp_a(input int t);
        logic [N*W-1:0] r = '0;
        for (int i = 0; i < N; i++)
            if (t - i >= 0 && t - i < N) r[i*W +: W] = opA[i][t - i];
        return r;
    endfunction

    function automatic logic [N*W-1:0] exp_b(input int t);
        logic [N*W-1:0] r = '0;
        for (int j = 0; j < N; j++)
            if (t - j >= 0 && t - j < N) r[j*W +: W] = opB[t - j][j];
        return r;
    endfunction

    task automatic rand_ops;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                opA[i][j] = W'($urandom);
                opB[i][j] = W'($urandom);
            end
    endtask

    // mode 0: valid whenever data remains; 1: valid toggles from the start cycle; 2: random gaps.
    // Sample n counts clock edges since (and including) the edge that sampled start.
    task automatic run_capture(input int mode, input bit busy);
        int  idx = 0;
        bit  pending = 0;
        bit  v;
        int  n = 0;
        int  after = 0;
        cap_a.delete(); cap_b.delete(); cap_n.delete();
        n_clr = -1; clr_cnt = 0; n_done = -1; done_cnt = 0;
        last_acc_n = -1; rdy_bad = 0; lane_bad = 0;
        @(negedge clk);
        start    = 1'b1;
        in_valid = (mode == 1);
        in_data  = '0;
        while (n < 300 && after < 12) begin
            @(negedge clk);
            n++;
            start = 1'b0;
            if (pending) begin
                idx++;
                if (idx == 2 * NN) last_acc_n = n;
            end
            if (acc_clr) begin clr_cnt++; n_clr = n; end
            if (feed_valid) begin
                cap_a.push_back(a_out);
                cap_b.push_back(b_out);
                cap_n.push_back(n);
            end else if ((|a_out) || (|b_out)) begin
                lane_bad++;
            end
            if (done) begin done_cnt++; n_done = n; end
            if (in_ready !== (last_acc_n < 0)) rdy_bad++;
            if (n_done >= 0) after++;
            if (busy && (n == 5 || (n_clr > 0 && n == n_clr + 2) || (done && n == n_done)))
                start = 1'b1;
            case (mode)
                0:       v = (idx < 2 * NN);
                1:       v = (idx < 2 * NN) && (n % 2 == 0);
                default: v = (idx < 2 * NN) && ($urandom_range(0, 1) == 1);
            endcase
            in_valid = v;
            in_data  = v ? elem(idx) : W'($urandom);
            pending  = v && in_ready;
        end
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
        repeat (3) @(negedge clk);
        total++;
        if ((in_ready | acc_clr | feed_valid | done | (|a_out) | (|b_out)) !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold: got rdy=%b clr=%b fv=%b done=%b a=%h b=%h want all 0",
                     in_ready, acc_clr, feed_valid, done, a_out, b_out);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ((in_ready | acc_clr | feed_valid | done) !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: got rdy=%b clr=%b fv=%b done=%b want all 0",
                     in_ready, acc_clr, feed_valid, done);
        end
    endtask

    task automatic test_skew;
        logic [N*W-1:0] ea [5];
        logic [N*W-1:0] eb [5];
        ea[0] = 24'h000001; ea[1] = 24'h000402; ea[2] = 24'h070503; ea[3] = 24'h080600; ea[4] = 24'h090000;
        eb[0] = 24'h00000A; eb[1] = 24'h000B0D; eb[2] = 24'h0C0E10; eb[3] = 24'h0F1100; eb[4] = 24'h120000;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                opA[i][j] = W'(i * N + j + 1);
                opB[i][j] = W'(10 + i * N + j);
            end
        run_capture(0, 1'b0);
        total++;
        if (cap_a.size() != 5) begin bad++; $display("FAIL skew_beats: got %0d want 5", cap_a.size()); end
        for (int t = 0; t < cap_a.size() && t < 5; t++) begin
            total++;
            if (cap_a[t] !== ea[t] || cap_b[t] !== eb[t]) begin
                bad++;
                $display("FAIL skew_t%0d: got a=%h b=%h want a=%h b=%h", t, cap_a[t], cap_b[t], ea[t], eb[t]);
            end
        end
        total++;
        if (clr_cnt != 1 || n_clr != 19) begin
            bad++; $display("FAIL skew_clr: got count=%0d at=%0d want count=1 at=19", clr_cnt, n_clr);
        end
        total++;
        if (cap_n.size() > 0 && cap_n[0] != 20) begin
            bad++; $display("FAIL skew_first_beat: got %0d want 20", cap_n[0]);
        end
        total++;
        if (done_cnt != 1 || n_done != 29) begin
            bad++; $display("FAIL skew_done: got count=%0d at=%0d want count=1 at=29", done_cnt, n_done);
        end
        total++;
        if (rdy_bad != 0 || lane_bad != 0) begin
            bad++; $display("FAIL skew_ready_lanes: got rdy_bad=%0d lane_bad=%0d want 0 0", rdy_bad, lane_bad);
        end
    endtask

    task automatic test_back_pressure;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                opA[i][j] = W'(i * N + j + 1);
                opB[i][j] = W'(10 + i * N + j);
            end
        run_capture(1, 1'b0);
        total++;
        if (cap_a.size() != 2 * N - 1) begin bad++; $display("FAIL bp_beats: got %0d want %0d", cap_a.size(), 2 * N - 1); end
        for (int t = 0; t < cap_a.size() && t < 2 * N - 1; t++) begin
            total++;
            if (cap_a[t] !== exp_a(t) || cap_b[t] !== exp_b(t)) begin
                bad++;
                $display("FAIL bp_t%0d: got a=%h b=%h want a=%h b=%h", t, cap_a[t], cap_b[t], exp_a(t), exp_b(t));
            end
        end
        total++;
        if (n_clr != 37 || done_cnt != 1 || n_done != 47) begin
            bad++; $display("FAIL bp_timing: got clr=%0d done=%0d x%0d want clr=37 done=47 x1", n_clr, n_done, done_cnt);
        end
        total++;
        if (rdy_bad != 0) begin bad++; $display("FAIL bp_ready: got %0d bad cycles want 0", rdy_bad); end
    endtask

    task automatic test_random;
        for (int it = 0; it < 4; it++) begin
            rand_ops();
            run_capture(2, 1'b0);
            total++;
            if (cap_a.size() != 2 * N - 1) begin bad++; $display("FAIL rnd%0d_beats: got %0d want %0d", it, cap_a.size(), 2 * N - 1); end
            for (int t = 0; t < cap_a.size() && t < 2 * N - 1; t++) begin
                total++;
                if (cap_a[t] !== exp_a(t) || cap_b[t] !== exp_b(t)) begin
                    bad++;
                    $display("FAIL rnd%0d_t%0d: got a=%h b=%h want a=%h b=%h", it, t, cap_a[t], cap_b[t], exp_a(t), exp_b(t));
                end
            end
            total++;
            if (last_acc_n < 0 || n_clr != last_acc_n || n_done != last_acc_n + 2 * N + D || done_cnt != 1) begin
                bad++;
                $display("FAIL rnd%0d_timing: got clr=%0d done=%0d x%0d want clr=%0d done=%0d x1",
                         it, n_clr, n_done, done_cnt, last_acc_n, last_acc_n + 2 * N + D);
            end
            total++;
            if (rdy_bad != 0 || lane_bad != 0) begin
                bad++; $display("FAIL rnd%0d_ready_lanes: got %0d %0d want 0 0", it, rdy_bad, lane_bad);
            end
        end
    endtask

    task automatic test_busy_start;
        rand_ops();
        run_capture(0, 1'b1);
        total++;
        if (done_cnt != 1 || n_done != 29) begin
            bad++; $display("FAIL busy_done: got count=%0d at=%0d want count=1 at=29", done_cnt, n_done);
        end
        total++;
        if (rdy_bad != 0) begin bad++; $display("FAIL busy_ready: got %0d bad cycles want 0", rdy_bad); end
        total++;
        if (cap_a.size() != 2 * N - 1) begin bad++; $display("FAIL busy_beats: got %0d want %0d", cap_a.size(), 2 * N - 1); end
        for (int t = 0; t < cap_a.size() && t < 2 * N - 1; t++) begin
            total++;
            if (cap_a[t] !== exp_a(t) || cap_b[t] !== exp_b(t)) begin
                bad++;
                $display("FAIL busy_t%0d: got a=%h b=%h want a=%h b=%h", t, cap_a[t], cap_b[t], exp_a(t), exp_b(t));
            end
        end
    endtask

    task automatic test_reset_mid_feed;
        bit seen = 0;
        rand_ops();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int k = 0; k < 2 * NN; k++) begin
            in_valid = 1'b1; in_data = elem(k);
            @(negedge clk);
        end
        in_valid = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            if (feed_valid) seen = 1;
            else @(negedge clk);
        end
        total++;
        if (!seen) begin bad++; $display("FAIL rst_feed_start: got no feed beat want one within 10 cycles"); end
        repeat (2) @(negedge clk);
        total++;
        if (a_out !== exp_a(2) || b_out !== exp_b(2)) begin
            bad++; $display("FAIL rst_pre_t2: got a=%h b=%h want a=%h b=%h", a_out, b_out, exp_a(2), exp_b(2));
        end
        #1 reset = 1'b1;
        #1;
        total++;
        if ((in_ready | acc_clr | feed_valid | done | (|a_out) | (|b_out)) !== 1'b0) begin
            bad++;
            $display("FAIL rst_async: got rdy=%b clr=%b fv=%b done=%b a=%h b=%h want all 0",
                     in_ready, acc_clr, feed_valid, done, a_out, b_out);
        end
        #2 reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            total++;
            if ((in_ready | feed_valid | acc_clr | done) !== 1'b0) begin
                bad++; $display("FAIL rst_idle_c%0d: got rdy=%b fv=%b clr=%b done=%b want 0 0 0 0",
                                c, in_ready, feed_valid, acc_clr, done);
            end
            in_valid = 1'b1; in_data = 8'hFF;
        end
        in_valid = 1'b0;
        rand_ops();
        run_capture(0, 1'b0);
        total++;
        if (cap_a.size() != 2 * N - 1 || n_done != 29) begin
            bad++; $display("FAIL rst_rerun: got beats=%0d done=%0d want %0d 29", cap_a.size(), n_done, 2 * N - 1);
        end
        for (int t = 0; t < cap_a.size() && t < 2 * N - 1; t++) begin
            total++;
            if (cap_a[t] !== exp_a(t) || cap_b[t] !== exp_b(t)) begin
                bad++;
                $display("FAIL rst_rerun_t%0d: got a=%h b=%h want a=%h b=%h", t, cap_a[t], cap_b[t], exp_a(t), exp_b(t));
            end
        end
    endtask

    task automatic test_idle_valid;
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            in_valid = 1'b1; in_data = 8'hFF;
            @(negedge clk);
            total++;
            if (in_ready !== 1'b0) begin bad++; $display("FAIL idle_ready_c%0d: got %b want 0", c, in_ready); end
        end
        in_valid = 1'b0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                opA[i][j] = '0;
                opB[i][j] = '0;
            end
        run_capture(0, 1'b0);
        total++;
        if (cap_a.size() != 2 * N - 1 || n_done != 29) begin
            bad++; $display("FAIL idle_run: got beats=%0d done=%0d want %0d 29", cap_a.size(), n_done, 2 * N - 1);
        end
        for (int t = 0; t < cap_a.size(); t++) begin
            total++;
            if ((|cap_a[t]) || (|cap_b[t])) begin
                bad++; $display("FAIL idle_zero_t%0d: got a=%h b=%h want 0 0", t, cap_a[t], cap_b[t]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_skew();
        test_back_pressure();
        test_random();
        test_busy_start();
        test_reset_mid_feed();
        test_idle_valid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
